tx_frame_ctrl: RTL and testbench

Transmit framing controller for the pattern-generator transmitter. It drives the 112-bit header shift register's load and shift strobes, takes each header byte from it, appends a generated payload, and presents the complete frame as an 8-bit AXI-Stream master toward the tri-mode Ethernet MAC. The MAC appends preamble and FCS; this block emits destination MAC, source MAC, EtherType, then payload.

---
 rtl/tx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tx_frame_ctrl
//
// Transmit framing controller. Sequences one Ethernet frame (without preamble
// or FCS) onto an 8-bit AXI-Stream master: HDR_BYTES header bytes taken from an
// external 112-bit header shift register, then a generated payload whose
// length is latched (and clamped) at start.
//
// Optional feature macro: TX_PRBS_PAYLOAD_EN
//   undefined : payload is an incrementing byte starting at 0x00 each frame
//   defined   : payload is an 8-bit Fibonacci LFSR seeded with 0xFF each frame
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, payload_len  frame request and its payload length (sampled in IDLE)
//   header_bits         current header byte from the shift register
//   shift_wr, shift_en  header shift-register load / rotate strobes
//   tx_tdata/tvalid/tlast, tx_tready   AXI-Stream master toward the MAC
//   busy                high whenever not IDLE
//   frame_done          one-cycle pulse, first GAP cycle after the last beat
//   frame_count         completed frames, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module tx_frame_ctrl #(
    parameter int HDR_BYTES  = 14,
    parameter int LEN_W      = 11,
    parameter int GAP_CYCLES = 12,
    parameter int MIN_LEN    = 46,
    parameter int MAX_LEN    = 1500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       header_bits,
    output logic             shift_wr,
    output logic             shift_en,
    output logic [7:0]       tx_tdata,
    output logic             tx_tvalid,
    output logic             tx_tlast,
    input  logic             tx_tready,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_GAP
    } state_t;

`ifdef TX_PRBS_PAYLOAD_EN
    localparam logic [7:0] PAY_SEED = 8'hFF;

    function automatic logic [7:0] pay_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
`else
    localparam logic [7:0] PAY_SEED = 8'h00;

    function automatic logic [7:0] pay_next(input logic [7:0] v);
        return v + 8'd1;
    endfunction
`endif

    state_t             state, state_nxt;
    logic [3:0]         beat_cnt;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   len_clamped;
    logic [7:0]         pay_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic               hs;

    // tvalid/tlast are decoded straight from the state register, so an
    // asynchronous reset removes tvalid immediately without waiting for a clock.
    assign hs   = tx_tvalid & tx_tready;
    assign busy = (state != S_IDLE);

    always_comb begin
        if (payload_len < LEN_W'(MIN_LEN))
            len_clamped = LEN_W'(MIN_LEN);
        else if (payload_len > LEN_W'(MAX_LEN))
            len_clamped = LEN_W'(MAX_LEN);
        else
            len_clamped = payload_len;
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        shift_wr  = 1'b0;
        shift_en  = 1'b0;
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        tx_tdata  = 8'h00;
        case (state)
            S_IDLE: begin
                shift_wr = start;
                if (start)
                    state_nxt = S_HEADER;
            end
            S_HEADER: begin
                tx_tvalid = 1'b1;
                tx_tdata  = header_bits;
                // header_bits only moves on shift_en, so data is stable under stall
                shift_en  = tx_tready;
                if (tx_tready && beat_cnt == 4'(HDR_BYTES - 1))
                    state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_tvalid = 1'b1;
                tx_tdata  = pay_q;
                tx_tlast  = (byte_cnt == LEN_W'(1));
                if (tx_tready && tx_tlast)
                    state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            byte_cnt    <= '0;
            pay_q       <= '0;
            gap_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= (state == S_PAYLOAD) && hs && tx_tlast;
            if ((state == S_PAYLOAD) && hs && tx_tlast)
                frame_count <= frame_count + 16'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        beat_cnt <= '0;
                        byte_cnt <= len_clamped;
                        pay_q    <= PAY_SEED;
                    end
                end
                S_HEADER: begin
                    if (hs)
                        beat_cnt <= beat_cnt + 4'd1;
                end
                S_PAYLOAD: begin
                    gap_cnt <= '0;
                    if (hs) begin
                        byte_cnt <= byte_cnt - LEN_W'(1);
                        pay_q    <= pay_next(pay_q);
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_ctrl
//
// Self-checking bench for tx_frame_ctrl. A table of frame requests is applied
// in a loop; expected beats (header bytes from a random header, then the
// payload pattern) are queued when a frame is requested and popped on every
// AXI handshake. A small cycle model tracks busy/frame_done/frame_count.
// Hand-written sequences cover mid-frame reset and ignored start pulses.
// -----------------------------------------------------------------------------
module tb_tx_frame_ctrl;

    localparam int HDR_BYTES  = 14;
    localparam int GAP_CYCLES = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [10:0]  payload_len;
    logic [7:0]   header_bits;
    logic         shift_wr;
    logic         shift_en;
    logic [7:0]   tx_tdata;
    logic         tx_tvalid;
    logic         tx_tlast;
    logic         tx_tready;
    logic         busy;
    logic         frame_done;
    logic [15:0]  frame_count;

    always #5 clk = ~clk;

    tx_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .payload_len (payload_len),
        .header_bits (header_bits),
        .shift_wr    (shift_wr),
        .shift_en    (shift_en),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tlast    (tx_tlast),
        .tx_tready   (tx_tready),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    // External 112-bit header shift register: load on shift_wr, rotate a byte
    // on shift_en, top byte presented as header_bits.
    logic [111:0] hdr_sr   = '0;
    logic [111:0] hdr_load = '0;

    always @(posedge clk) begin
        if (shift_wr)
            hdr_sr <= hdr_load;
        else if (shift_en)
            hdr_sr <= {hdr_sr[103:0], hdr_sr[111:104]};
    end
    assign header_bits = hdr_sr[111:104];

    // Scoreboard and cycle model
    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        m_busy, gap_on, done_pend, prev_stall, prev_last;
    logic [7:0]  prev_data;
    logic [15:0] exp_count;
    int          m_left, hs_seen;

    typedef struct {
        logic [10:0] len;
        int          beats;
        bit          stall;
        bit          poke;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pay_seed();
`ifdef TX_PRBS_PAYLOAD_EN
        return 8'hFF;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] pay_step(input logic [7:0] v);
`ifdef TX_PRBS_PAYLOAD_EN
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        return v + 8'd1;
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_busy     = 1'b0;
        gap_on     = 1'b0;
        done_pend  = 1'b0;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'h00;
        exp_count  = 16'd0;
        m_left     = 0;
        hs_seen    = 0;
    endtask

    // Compare all outputs for the current cycle, then advance the model.
    task automatic monitor(input logic st);
        beat_t b;
        logic  hs;
        logic  idle_now;
        hs       = tx_tvalid && tx_tready;
        idle_now = !m_busy;

        check("frame_done", 32'(frame_done), 32'(done_pend));
        if (done_pend)
            exp_count = exp_count + 16'd1;
        check("frame_count", 32'(frame_count), 32'(exp_count));
        check("busy", 32'(busy), 32'(m_busy));
        check("shift_wr", 32'(shift_wr), 32'(st && idle_now));
        check("tvalid", 32'(tx_tvalid), 32'(m_busy && exp_q.size() != 0));
        check("shift_en", 32'(shift_en), 32'(hs && hs_seen < HDR_BYTES));
        if (prev_stall) begin
            check("stall_tdata", 32'(tx_tdata), 32'(prev_data));
            check("stall_tlast", 32'(tx_tlast), 32'(prev_last));
        end

        if (done_pend) begin
            gap_on = 1'b1;
            m_left = GAP_CYCLES;
        end
        done_pend = 1'b0;

        if (hs) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got tdata 0x%0h with no beat expected", tx_tdata);
            end else begin
                b = exp_q.pop_front();
                check("tdata", 32'(tx_tdata), 32'(b.data));
                check("tlast", 32'(tx_tlast), 32'(b.last));
                done_pend = b.last;
            end
            hs_seen++;
        end

        prev_stall = tx_tvalid && !tx_tready;
        prev_data  = tx_tdata;
        prev_last  = tx_tlast;

        if (gap_on) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                gap_on = 1'b0;
            end
        end
        if (st && idle_now) begin
            m_busy  = 1'b1;
            hs_seen = 0;
        end
    endtask

    // Drive inputs just after the falling edge, sample #1 later.
    task automatic tick(input logic st, input logic rdy);
        @(negedge clk);
        start     = st;
        tx_tready = rdy;
        #1;
        monitor(st);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_tlast", 32'(tx_tlast), 32'd0);
        check("rst_tdata", 32'(tx_tdata), 32'd0);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Queue the expected beats for one frame with a fresh random header.
    task automatic queue_frame(input logic [10:0] len, input int beats);
        beat_t      b;
        logic [7:0] v;
        hdr_load    = {16'($urandom), $urandom, $urandom, $urandom};
        payload_len = len;
        for (int i = 0; i < HDR_BYTES; i++) begin
            b.data = hdr_load[111 - 8*i -: 8];
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        v = pay_seed();
        for (int j = 0; j < beats; j++) begin
            b.data = v;
            b.last = (j == beats - 1);
            exp_q.push_back(b);
            v = pay_step(v);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int   cnt;
        int   budget;
        logic rdy;
        logic st;
        queue_frame(v.len, v.beats);
        tick(1'b1, 1'b1);
        cnt    = 0;
        budget = 4 * (v.beats + 40);
        while (m_busy && cnt < budget) begin
            cnt++;
            rdy = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            // start pulses during PAYLOAD and during GAP must be ignored
            st  = v.poke && (cnt == 20 || cnt == 14 + v.beats + 4);
            tick(st, rdy);
        end
        check("frame_timeout", 32'(cnt >= budget), 32'd0);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        if (!v.stall)
            check("start_to_idle_cycles", 32'(cnt + 1), 32'(15 + v.beats + GAP_CYCLES));
        exp_q.delete();
    endtask

    initial begin
        start       = 1'b0;
        tx_tready   = 1'b0;
        payload_len = '0;
        rst_n       = 1'b1;
        model_clear();

        vecs[0] = '{len: 11'd46,   beats: 46,   stall: 1'b0, poke: 1'b0};
        vecs[1] = '{len: 11'd10,   beats: 46,   stall: 1'b0, poke: 1'b0};
        vecs[2] = '{len: 11'd2000, beats: 1500, stall: 1'b0, poke: 1'b0};
        vecs[3] = '{len: 11'd47,   beats: 47,   stall: 1'b1, poke: 1'b0};
        vecs[4] = '{len: 11'd100,  beats: 100,  stall: 1'b1, poke: 1'b0};
        vecs[5] = '{len: 11'd60,   beats: 60,   stall: 1'b0, poke: 1'b1};
        vecs[6] = '{len: 11'd46,   beats: 46,   stall: 1'b0, poke: 1'b0};
        vecs[7] = '{len: 11'd1500, beats: 1500, stall: 1'b1, poke: 1'b0};

        #2;
        apply_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // Mid-frame reset after five header handshakes: tvalid drops at once,
        // the partial frame is not counted.
        begin
            int n;
            queue_frame(11'd46, 46);
            tick(1'b1, 1'b1);
            n = 0;
            while (hs_seen < 5 && n < 20) begin
                n++;
                tick(1'b0, 1'b1);
            end
            check("reset_beat5_reached", 32'(hs_seen), 32'd5);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst_tvalid", 32'(tx_tvalid), 32'd0);
            check("async_rst_count", 32'(frame_count), 32'd0);
            apply_reset();
            tick(1'b0, 1'b1);
        end

        // Table frames, back to back: each start lands on the first IDLE cycle.
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i]);

        tick(1'b0, 1'b1);
        check("final_frame_count", 32'(frame_count), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
